// File: rtl/exe_div_unit_if.sv
// Pipeline <-> EXE divider signal bundle. The pipeline (master) presents a
// divide on is_div/src_a/src_b; the divider (slave) returns stall and results.
interface exe_div_unit_if #(
  parameter int WIDTH = 32
);
  // Handshake: is_div (01/10) is "valid" and is sampled only while the divider
  // is idle. stall_req is the inverse of "ready": while it is high the
  // instruction must stay put with is_div held. The request is consumed when
  // the divider leaves IDLE. result_valid pulses for one cycle with
  // hi_out/lo_out, and there is no back-pressure on the result.
  logic [1:0]       is_div;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             stall_req;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic [1:0]       state;   // debug view of the divider FSM (0 IDLE, 1 BUSY, 2 DONE)

  modport master (
    output is_div, src_a, src_b, cancel,
    input  stall_req, busy, result_valid, hi_out, lo_out, state
  );

  modport slave (
    input  is_div, src_a, src_b, cancel,
    output stall_req, busy, result_valid, hi_out, lo_out, state
  );
endinterface

// File: rtl/exe_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EXE stage.
// It stalls the pipeline for WIDTH+1 cycles and produces the remainder on hi_out and the quotient on lo_out.
module exe_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clock,
  input  logic           reset,
  exe_div_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] divisor, rem, quo;
  logic [CNT_W-1:0] count;
  logic             sign_q, sign_r, div_zero;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             result_valid_q;

  logic             is_signed, is_op, start, last_iter, fits;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_shift, rem_diff;
  logic [WIDTH-1:0] rem_step, quo_step, lo_final, hi_final;

  assign is_signed = (bus.is_div == 2'b01);
  assign is_op     = is_signed || (bus.is_div == 2'b10);
  assign start     = (state == IDLE) && is_op && !bus.cancel;

  assign a_mag = (is_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign b_mag = (is_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract if it fits. The compare is WIDTH+1 bits wide so that the shifted-out MSB counts.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, divisor};
  assign fits      = (rem_shift >= {1'b0, divisor});
  assign rem_step  = fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_step  = {quo[WIDTH-2:0], fits};
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  // With a zero divisor every step "fits", so the quotient is all ones and the
  // remainder is |a|. Re-applying sign_r to that remainder gives back the raw
  // dividend, so only the quotient needs an explicit override.
  assign lo_final = div_zero ? '1 : (sign_q ? -quo_step : quo_step);
  assign hi_final = sign_r ? -rem_step : rem_step;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.cancel) state_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      divisor        <= '0;
      rem            <= '0;
      quo            <= '0;
      sign_q         <= 1'b0;
      sign_r         <= 1'b0;
      div_zero       <= 1'b0;
      hi_q           <= '0;
      lo_q           <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state          <= state_next;
      result_valid_q <= 1'b0;
      if (bus.cancel) begin
        count <= '0;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            divisor  <= b_mag;
            quo      <= a_mag;
            rem      <= '0;
            count    <= '0;
            sign_q   <= is_signed && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            sign_r   <= is_signed && bus.src_a[WIDTH-1];
            div_zero <= (bus.src_b == '0);
          end
          BUSY: begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count + 1'b1;
            if (last_iter) begin
              hi_q           <= hi_final;
              lo_q           <= lo_final;
              result_valid_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.stall_req    = (start || (state == BUSY)) && !bus.cancel;
  assign bus.busy         = (state != IDLE);
  assign bus.result_valid = result_valid_q;
  assign bus.hi_out       = hi_q;
  assign bus.lo_out       = lo_q;
  assign bus.state        = state;
endmodule

// File: tb/tb_exe_div_unit.sv
// Directed bench for exe_div_unit: latency, signed/unsigned results, divide by
// zero, overflow, cancel, back-to-back issue and mid-division reset.
module tb_exe_div_unit;
  localparam int WIDTH = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  exe_div_unit_if #(.WIDTH(WIDTH)) bus ();

  exe_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle++;

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one divide at a falling edge, hold is_div as the stalled pipeline
  // would, and stop in the DONE cycle (result_valid high).
  task automatic do_div(input string tag, input logic [1:0] mode,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] ex_lo, input logic [WIDTH-1:0] ex_hi,
                        output int done_cycle);
    int cyc    = 0;
    int stalls = 0;
    bit got    = 1'b0;
    @(negedge clock);
    bus.is_div = mode;
    bus.src_a  = a;
    bus.src_b  = b;
    #1;
    while (!got && cyc < 100) begin
      if (bus.result_valid) begin
        got = 1'b1;
      end else begin
        if (bus.stall_req) stalls++;
        if (cyc == 3) begin
          bus.src_a = $urandom;
          bus.src_b = $urandom;
        end
        @(negedge clock);
        #1;
        cyc++;
      end
    end
    check({tag, " result_valid seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, cyc, 32'd33);
    check({tag, " stall cycles"}, stalls, 32'd33);
    check({tag, " stall_req in DONE"}, 32'(bus.stall_req), 32'd0);
    check({tag, " lo_out"}, bus.lo_out, ex_lo);
    check({tag, " hi_out"}, bus.hi_out, ex_hi);
    done_cycle = cycle;
  endtask

  task automatic go_idle();
    @(negedge clock);
    bus.is_div = 2'b00;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, pulses;

    bus.is_div = 2'b00;
    bus.src_a  = '0;
    bus.src_b  = '0;
    bus.cancel = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check("reset state", 32'(bus.state), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset stall_req", 32'(bus.stall_req), 32'd0);
    check("reset result_valid", 32'(bus.result_valid), 32'd0);
    check("reset hi_out", bus.hi_out, 32'd0);
    check("reset lo_out", bus.lo_out, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // is_div=11 is not a divide
    bus.is_div = 2'b11;
    bus.src_a  = 32'd10;
    bus.src_b  = 32'd2;
    #1;
    check("is_div 11 stall_req", 32'(bus.stall_req), 32'd0);
    @(negedge clock);
    #1;
    check("is_div 11 busy", 32'(bus.busy), 32'd0);
    bus.is_div = 2'b00;

    do_div("divu 100/7", 2'b10, 32'd100, 32'd7, 32'd14, 32'd2, t0);
    go_idle();
    do_div("div -7/2", 2'b01, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, t0);
    go_idle();
    do_div("div 7/-2", 2'b01, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, t0);
    go_idle();
    do_div("div overflow", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, t0);
    go_idle();
    do_div("div -5/0", 2'b01, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, t0);
    go_idle();
    do_div("divu x/0", 2'b10, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, t0);
    go_idle();

    // Cancel at BUSY iteration 10 (cycle 11 after the issue cycle)
    @(negedge clock);
    bus.is_div = 2'b10;
    bus.src_a  = 32'd1000;
    bus.src_b  = 32'd3;
    repeat (11) @(negedge clock);
    bus.cancel = 1'b1;
    #1;
    check("cancel stall_req drops", 32'(bus.stall_req), 32'd0);
    check("cancel still busy", 32'(bus.busy), 32'd1);
    @(negedge clock);
    bus.cancel = 1'b0;
    bus.is_div = 2'b00;
    #1;
    check("cancel idle state", 32'(bus.state), 32'd0);
    check("cancel no result_valid", 32'(bus.result_valid), 32'd0);
    check("cancel hi kept", bus.hi_out, 32'h1234_5678);
    check("cancel lo kept", bus.lo_out, 32'hFFFF_FFFF);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      #1;
      if (bus.result_valid) pulses++;
    end
    check("cancel no late pulse", pulses, 32'd0);
    do_div("divu 9/3 after cancel", 2'b10, 32'd9, 32'd3, 32'd3, 32'd0, t0);

    // Back-to-back: the second divide is presented the cycle after DONE
    do_div("divu 50/5", 2'b10, 32'd50, 32'd5, 32'd10, 32'd0, t0);
    do_div("divu 50/6", 2'b10, 32'd50, 32'd6, 32'd8, 32'd2, t1);
    check("back-to-back spacing", t1 - t0, 32'd34);
    go_idle();

    // Reset in the middle of a division
    @(negedge clock);
    bus.is_div = 2'b10;
    bus.src_a  = 32'd77;
    bus.src_b  = 32'd5;
    repeat (6) @(negedge clock);
    reset      = 1'b1;
    bus.is_div = 2'b00;
    @(negedge clock);
    #1;
    check("mid reset state", 32'(bus.state), 32'd0);
    check("mid reset busy", 32'(bus.busy), 32'd0);
    check("mid reset stall_req", 32'(bus.stall_req), 32'd0);
    check("mid reset result_valid", 32'(bus.result_valid), 32'd0);
    check("mid reset hi_out", bus.hi_out, 32'd0);
    check("mid reset lo_out", bus.lo_out, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
